uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 21 ++
 rtl/uart_rx_fifo.sv | 125 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: parameter defaults and the
// stored entry layout.
package uart_rx_fifo_pkg;

    localparam int UART_RX_DEPTH_DEFAULT      = 8;
    localparam int UART_RX_HIGH_WATER_DEFAULT = 6;
    localparam int UART_RX_LOW_WATER_DEFAULT  = 2;

    localparam int UART_RX_ENTRY_W = 9;

    // One received character with the framing flag captured alongside it.
    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
    } rx_entry_t;

    function automatic int rx_level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO between the UART receiver and the host data register:
// show-ahead head entry, sticky overrun, and rts_b flow control with hysteresis.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH      = UART_RX_DEPTH_DEFAULT,
    parameter int HIGH_WATER = UART_RX_HIGH_WATER_DEFAULT,
    parameter int LOW_WATER  = UART_RX_LOW_WATER_DEFAULT
) (
    input  logic                              clk,
    input  logic                              reset_b,
    input  logic [7:0]                        rx_data,
    input  logic                              rx_ferr,
    input  logic                              rx_valid,
    input  logic                              host_rd,
    output logic [7:0]                        host_dout,
    output logic                              host_dor,
    output logic                              frame_error,
    output logic                              overrun,
    output logic [rx_level_width(DEPTH)-1:0]  level,
    output logic                              rts_b
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_HIGH = LVL_W'(HIGH_WATER);
    localparam logic [LVL_W-1:0] LVL_LOW  = LVL_W'(LOW_WATER);

    rx_entry_t        mem [DEPTH];
    rx_entry_t        head;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_nxt;

    logic             host_rd_q;
    logic             rd_armed;
    logic             pop_q;

    logic             empty;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_FULL);

    // A registered pop request against an empty FIFO is simply discarded.
    assign pop  = pop_q & ~empty;
    assign push = rx_valid & (~full | pop);
    assign drop = rx_valid & full & ~pop;

    always_comb begin
        level_nxt = level_q;
        if (push && !pop) begin
            level_nxt = level_q + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level_q - 1'b1;
        end
    end

    // rd_armed blocks the edge detector until host_rd has been seen low after
    // reset, so a read strobe already high at release does not pop.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            host_rd_q <= 1'b0;
            rd_armed  <= 1'b0;
            pop_q     <= 1'b0;
        end else begin
            host_rd_q <= host_rd;
            if (!host_rd) begin
                rd_armed <= 1'b1;
            end
            pop_q <= host_rd & ~host_rd_q & rd_armed;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            overrun <= 1'b0;
            rts_b   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_nxt;

            if (drop) begin
                overrun <= 1'b1;
            end else if (pop) begin
                overrun <= 1'b0;
            end

            // Hysteresis band: between the marks the previous state is held.
            if (level_nxt >= LVL_HIGH) begin
                rts_b <= 1'b1;
            end else if (level_nxt <= LVL_LOW) begin
                rts_b <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_entry_t'{ferr: rx_ferr, data: rx_data};
        end
    end

    assign head        = mem[rd_ptr];
    assign host_dout   = empty ? 8'h00 : head.data;
    assign frame_error = ~empty & head.ferr;
    assign host_dor    = ~empty;
    assign level       = level_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic, all
// checked against a queue-based reference model sampled on the falling edge.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int HW    = 6;
    localparam int LW    = 2;

    logic       clk = 1'b0;
    logic       reset_b;
    logic [7:0] rx_data;
    logic       rx_ferr;
    logic       rx_valid;
    logic       host_rd;
    logic [7:0] host_dout;
    logic       host_dor;
    logic       frame_error;
    logic       overrun;
    logic [3:0] level;
    logic       rts_b;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .HIGH_WATER(HW), .LOW_WATER(LW)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .rx_data     (rx_data),
        .rx_ferr     (rx_ferr),
        .rx_valid    (rx_valid),
        .host_rd     (host_rd),
        .host_dout   (host_dout),
        .host_dor    (host_dor),
        .frame_error (frame_error),
        .overrun     (overrun),
        .level       (level),
        .rts_b       (rts_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents as a queue of {ferr, data}.
    logic [8:0] exp_q[$];
    bit         m_ovr;
    bit         m_rts;
    bit         m_prev_rd;
    bit         m_pop_pend;

    always @(negedge clk) begin
        logic [8:0] head;
        logic [8:0] got;
        bit         pop;
        bit         drop;
        if (!reset_b) begin
            exp_q.delete();
            m_ovr      = 0;
            m_rts      = 0;
            m_prev_rd  = 1;
            m_pop_pend = 0;
            chk("rst_level", int'(level), 0);
            chk("rst_dor", int'(host_dor), 0);
            chk("rst_dout", int'(host_dout), 0);
            chk("rst_ferr", int'(frame_error), 0);
            chk("rst_ovr", int'(overrun), 0);
            chk("rst_rts", int'(rts_b), 0);
        end else begin
            head = (exp_q.size() != 0) ? exp_q[0] : 9'h000;
            chk("level", int'(level), exp_q.size());
            chk("dor", int'(host_dor), int'(exp_q.size() != 0));
            chk("head_dout", int'(host_dout), int'(head[7:0]));
            chk("head_ferr", int'(frame_error), int'(head[8]));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("rts_b", int'(rts_b), int'(m_rts));

            pop  = m_pop_pend && (exp_q.size() != 0);
            drop = 0;
            if (pop) begin
                got = exp_q.pop_front();
                chk("read_entry", int'({frame_error, host_dout}), int'(got));
            end
            if (rx_valid) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({rx_ferr, rx_data});
                else drop = 1;
            end
            if (drop) m_ovr = 1;
            else if (pop) m_ovr = 0;
            if (exp_q.size() >= HW) m_rts = 1;
            else if (exp_q.size() <= LW) m_rts = 0;
            m_pop_pend = host_rd && !m_prev_rd;
            m_prev_rd  = host_rd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic fe);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_ferr  = fe;
        tick();
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
    endtask

    task automatic read_pulse(input int len);
        host_rd = 1'b1;
        repeat (len) tick();
        host_rd = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int prob;
        reset_b  = 1'b0;
        rx_data  = 8'h00;
        rx_ferr  = 1'b0;
        rx_valid = 1'b0;
        host_rd  = 1'b0;
        repeat (3) tick();
        reset_b = 1'b1;
        tick();

        // Two pushes, one long read strobe.
        send(8'h41, 1'b0);
        chk("dor_one_clock", int'(host_dor), 1);
        send(8'h42, 1'b0);
        chk("show_ahead_41", int'(host_dout), 8'h41);
        read_pulse(5);
        chk("after_read_42", int'(host_dout), 8'h42);
        chk("after_read_level", int'(level), 1);
        read_pulse(2);

        // Overfill by one.
        for (int i = 0; i < 9; i++) send(8'(i), 1'b0);
        chk("overfill_level", int'(level), 8);
        chk("overfill_ovr", int'(overrun), 1);
        read_pulse(1);
        chk("ovr_cleared", int'(overrun), 0);
        for (int i = 0; i < 7; i++) read_pulse(1);
        chk("drained", int'(level), 0);

        // Push coincident with pop while full.
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
        host_rd = 1'b1;
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        tick();
        rx_valid = 1'b0;
        host_rd  = 1'b0;
        tick();
        chk("full_swap_level", int'(level), 8);
        chk("full_swap_ovr", int'(overrun), 0);
        for (int i = 0; i < 7; i++) read_pulse(1);
        chk("swap_last", int'(host_dout), 8'hA5);
        read_pulse(1);

        // Flow-control hysteresis.
        for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), 1'b0);
        tick();
        chk("rts_high", int'(rts_b), 1);
        for (int i = 0; i < 3; i++) read_pulse(1);
        chk("rts_hold_l3", int'(rts_b), 1);
        read_pulse(1);
        chk("rts_low_l2", int'(rts_b), 0);
        read_pulse(1);
        read_pulse(1);

        // Framing flag follows the head entry.
        send(8'h55, 1'b1);
        chk("ferr_head", int'(frame_error), 1);
        chk("ferr_data", int'(host_dout), 8'h55);
        read_pulse(1);
        chk("ferr_cleared", int'(frame_error), 0);
        chk("empty_dout", int'(host_dout), 0);

        // Reset at level 5 with host_rd held high across release.
        for (int i = 0; i < 5; i++) send(8'h80 + 8'(i), 1'b0);
        host_rd = 1'b1;
        reset_b = 1'b0;
        tick();
        tick();
        reset_b = 1'b1;
        repeat (3) tick();
        chk("post_rst_level", int'(level), 0);
        chk("post_rst_dor", int'(host_dor), 0);
        send(8'h77, 1'b0);
        repeat (3) tick();
        chk("no_pop_held_rd", int'(level), 1);
        host_rd = 1'b0;
        tick();
        read_pulse(1);
        chk("pop_after_toggle", int'(level), 0);

        // Randomized traffic with varying push density and occasional resets.
        hold = 0;
        prob = 40;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) prob = $urandom_range(5, 90);
            rx_valid = ($urandom_range(0, 99) < prob);
            rx_data  = 8'($urandom);
            rx_ferr  = ($urandom_range(0, 7) == 0);
            if (hold == 0) begin
                host_rd = ~host_rd;
                hold = $urandom_range(1, 6);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 599) == 0) reset_b = 1'b0;
            else reset_b = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        host_rd  = 1'b0;
        reset_b  = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
